// File: rtl/qupls_alu_sequencer.sv
// Issue-side sequencer for the Qupls ALU lane: launches one op at a time, holds operands
// through multi-cycle mul/div, and hands the captured result to writeback with valid/ready.
module qupls_alu_sequencer #(
    parameter int WID     = 64,
    parameter int TAGW    = 9,
    parameter int DIV_TMO = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            iss_v,
    output logic            iss_rdy,
    input  logic [1:0]      iss_kind,
    input  logic            iss_sgn,
    input  logic [TAGW-1:0] iss_tag,
    output logic            alu_ld,
    output logic            alu_div,
    output logic            op_hold,
    input  logic [WID-1:0]  alu_o,
    input  logic            alu_mul_done,
    input  logic            alu_div_done,
    input  logic            alu_div_dbz,
    output logic            wb_v,
    input  logic            wb_rdy,
    output logic [TAGW-1:0] wb_tag,
    output logic [WID-1:0]  wb_res,
    output logic [1:0]      wb_exc
);

    typedef enum logic [2:0] {IDLE, LOAD, MWAIT, DWAIT, CAPT} state_t;

    localparam logic [1:0] KIND_MUL = 2'd1;
    localparam logic [1:0] KIND_DIV = 2'd2;
    localparam logic [1:0] EXC_NONE = 2'd0;
    localparam logic [1:0] EXC_DBZ  = 2'd1;
    localparam logic [1:0] EXC_TMO  = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(DIV_TMO - 1);

    state_t          state;
    logic [1:0]      kind;
    logic            sgn;
    logic [TAGW-1:0] tag;
    logic [7:0]      tmo;
    logic [1:0]      cap_exc;

    // Gating with rst keeps the sequencer from advertising space while reset is held.
    always_comb begin
        iss_rdy = rst & (state == IDLE) & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            kind    <= 2'd0;
            sgn     <= 1'b0;
            tag     <= '0;
            tmo     <= 8'd0;
            cap_exc <= EXC_NONE;
            alu_ld  <= 1'b0;
            alu_div <= 1'b0;
            op_hold <= 1'b0;
            wb_v    <= 1'b0;
            wb_tag  <= '0;
            wb_res  <= '0;
            wb_exc  <= EXC_NONE;
        end else begin
            alu_ld <= 1'b0;
            if (wb_v && wb_rdy)
                wb_v <= 1'b0;

            if (flush) begin
                state   <= IDLE;
                wb_v    <= 1'b0;
                tmo     <= 8'd0;
                op_hold <= 1'b0;
                alu_div <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (iss_v) begin
                            kind    <= iss_kind;
                            sgn     <= iss_sgn;
                            tag     <= iss_tag;
                            alu_ld  <= 1'b1;
                            op_hold <= 1'b1;
                            alu_div <= (iss_kind == KIND_DIV) & iss_sgn;
                            state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        tmo     <= 8'd0;
                        cap_exc <= EXC_NONE;
                        if (kind == KIND_MUL)
                            state <= MWAIT;
                        else if (kind == KIND_DIV)
                            state <= DWAIT;
                        else
                            state <= CAPT;
                    end
                    // tmo==0 marks the first MWAIT cycle, where mul_done is left over from a prior op.
                    MWAIT: begin
                        if (tmo == 8'd0)
                            tmo <= 8'd1;
                        else if (alu_mul_done)
                            state <= CAPT;
                    end
                    DWAIT: begin
                        tmo     <= tmo + 8'd1;
                        alu_div <= sgn;
                        if (tmo >= 8'd2 && alu_div_done) begin
                            cap_exc <= alu_div_dbz ? EXC_DBZ : EXC_NONE;
                            state   <= CAPT;
                        end else if (tmo == TMO_LAST) begin
                            cap_exc <= EXC_TMO;
                            state   <= CAPT;
                        end
                    end
                    CAPT: begin
                        if (!wb_v || wb_rdy) begin
                            wb_v    <= 1'b1;
                            wb_res  <= (cap_exc == EXC_TMO) ? '0 : alu_o;
                            wb_tag  <= tag;
                            wb_exc  <= cap_exc;
                            op_hold <= 1'b0;
                            alu_div <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
